// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl -- execute-stage multiply/divide sequencer.
// Holds the architectural HI/LO pair. It accepts mult/multu/div/divu and
// models a fixed multi-cycle latency through a down-counter. busy is exported
// so that the hazard unit can stall MD-class instructions in D.
// Optional build macro: MDU_DIVZERO_FAST_EN. When it is defined, a divide
// by zero is accepted without occupying the unit. When it is not defined,
// a divide by zero occupies the unit for the full DIV_CYCLES and then
// leaves HI/LO unchanged.
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    // Signed 32x32 -> 64 product, returned as {hi, lo}
    function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
    endfunction

    // Unsigned 32x32 -> 64 product, returned as {hi, lo}
    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Signed divide through magnitudes. The quotient truncates toward zero
    // and the remainder takes the dividend's sign. 0x80000000 / -1 then
    // falls out naturally as quotient 0x80000000 and remainder 0.
    function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r, qs, rs;
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        if (mb == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        qs = (a[31] ^ b[31]) ? (~q + 32'd1) : q;
        rs = a[31] ? (~r + 32'd1) : r;
        return {rs, qs};
    endfunction

    // Unsigned divide, returned as {remainder, quotient}
    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) begin
            return 64'd0;
        end
        return {a % b, a / b};
    endfunction

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;
    logic             is_md;
    logic             is_div;
    logic             b_zero;
    logic             accept;
    logic             commit;
    logic [63:0]      res_d;
    logic [63:0]      pend_p1;
    logic             pend_wr_p1;

    // Decode the E-stage op and decide whether a new MD operation is accepted
    always_comb begin
        is_md  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                 (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
        is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
        b_zero = (B == 32'd0);
        accept = start && !busy_q && !req && is_md;
        commit = (cnt_q == CNT_W'(1)) && pend_wr_p1;
    end

    // Next-state: load the latency on accept, count down while running
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (accept) begin
            if (is_div) begin
`ifdef MDU_DIVZERO_FAST_EN
                cnt_d = b_zero ? '0 : CNT_W'(DIV_CYCLES);
`else
                cnt_d = CNT_W'(DIV_CYCLES);
`endif
            end else begin
                cnt_d = CNT_W'(MULT_CYCLES);
            end
        end
    end

    // State register: the counter and a registered copy of busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    // Result of the E-stage op, formatted as {hi, lo}
    always_comb begin
        res_d = 64'd0;
        case (MDUOp)
            OP_MULT:  res_d = mul_s(A, B);
            OP_MULTU: res_d = mul_u(A, B);
            OP_DIV:   res_d = div_s(A, B);
            OP_DIVU:  res_d = div_u(A, B);
            default:  res_d = 64'd0;
        endcase
    end

    // Capture the pending result at accept; a divide by zero never writes back
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_p1    <= 64'd0;
            pend_wr_p1 <= 1'b0;
        end else if (accept) begin
            pend_p1    <= res_d;
            pend_wr_p1 <= !(is_div && b_zero);
        end
    end

    // Architectural HI/LO: commit at the final run edge, or mthi/mtlo while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (commit) begin
            HI <= pend_p1[63:32];
            LO <= pend_p1[31:0];
        end else if (!busy_q && !req) begin
            if (MDUOp == OP_MTHI) begin
                HI <= A;
            end
            if (MDUOp == OP_MTLO) begin
                LO <= A;
            end
        end
    end

    // Outputs: busy straight from its register, mfhi/mflo read HI/LO without bypass
    always_comb begin
        busy = busy_q;
        case (MDUOp)
            OP_MFHI: MDUOut = HI;
            OP_MFLO: MDUOut = LO;
            default: MDUOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Testbench for e_mdu_ctrl: directed literal cases plus randomized traffic.
// Both are checked every cycle against a behavioural HI/LO model.
module tb_e_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  MDUOp;
    logic        start;
    logic        req;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    bit          m_pwr = 1'b0;
    int          m_rem = 0;

    e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .MDUOp(MDUOp), .start(start), .req(req),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Architectural result of an MD op straight from the arithmetic rules
    function automatic void calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output bit wr);
        int          sa, sb, q, r;
        longint      p;
        logic [63:0] pu;
        sa = a; sb = b; h = 32'd0; l = 32'd0; wr = 1'b1;
        case (op)
            4'd1: begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
            4'd2: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
            4'd3: begin
                if (b == 32'd0) wr = 1'b0;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin l = a; h = 32'd0; end
                else begin q = sa / sb; r = sa % sb; l = q; h = r; end
            end
            4'd4: begin
                if (b == 32'd0) wr = 1'b0;
                else begin l = a / b; h = a % b; end
            end
            default: wr = 1'b0;
        endcase
    endfunction

    // Model: remaining busy cycles plus pending result; reset is asynchronous
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_hi = 0; m_lo = 0; m_rem = 0; m_pwr = 0; m_phi = 0; m_plo = 0;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0 && m_pwr) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
            end else if (start && !req && MDUOp >= 4'd1 && MDUOp <= 4'd4) begin
                calc(MDUOp, A, B, m_phi, m_plo, m_pwr);
                m_rem = (MDUOp >= 4'd3) ? DC : MC;
`ifdef MDU_DIVZERO_FAST_EN
                if (MDUOp >= 4'd3 && B == 32'd0) m_rem = 0;
`endif
            end else if (!req) begin
                if (MDUOp == 4'd7) m_hi = A;
                if (MDUOp == 4'd8) m_lo = A;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
                chk("HI", HI, m_hi);
                chk("LO", LO, m_lo);
                chk("MDUOut", MDUOut, (MDUOp == 4'd5) ? m_hi : ((MDUOp == 4'd6) ? m_lo : 32'd0));
            end
        end
    end

    // The hazard unit never issues start while the unit is busy
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            assert (!(start && busy)) else $error("start asserted while busy");
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
        @(posedge clk); #1;
        MDUOp = op; A = a; B = b; req = rq;
        start = (op >= 4'd1 && op <= 4'd4);
        @(posedge clk); #1;
        MDUOp = 4'd0; start = 1'b0; req = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
    endtask

    int n;

    initial begin
        reset_n = 1'b0; MDUOp = 4'd0; start = 1'b0; req = 1'b0; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // mult -1 * 2
        issue(4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        busy_len(n);
        chk("mult_busy_cycles", 32'(n), 32'd5);
        chk("mult_HI", HI, 32'hFFFFFFFF);
        chk("mult_LO", LO, 32'hFFFFFFFE);

        // multu with the same operands, then read back
        issue(4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        busy_len(n);
        chk("multu_busy_cycles", 32'(n), 32'd5);
        chk("multu_HI", HI, 32'h00000001);
        chk("multu_LO", LO, 32'hFFFFFFFE);
        @(posedge clk); #1; MDUOp = 4'd5;
        @(negedge clk);
        chk("mfhi_out", MDUOut, 32'h00000001);
        #1 MDUOp = 4'd6; #1;
        chk("mflo_out", MDUOut, 32'hFFFFFFFE);
        MDUOp = 4'd0;

        // div -7 / 2 and divu 7 / 2
        issue(4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        busy_len(n);
        chk("div_busy_cycles", 32'(n), 32'd10);
        chk("div_LO", LO, 32'hFFFFFFFD);
        chk("div_HI", HI, 32'hFFFFFFFF);
        issue(4'd4, 32'd7, 32'd2, 1'b0);
        busy_len(n);
        chk("divu_LO", LO, 32'd3);
        chk("divu_HI", HI, 32'd1);

        // Flush suppression
        issue(4'd7, 32'h12345678, 32'd0, 1'b1);
        @(negedge clk);
        chk("mthi_req_HI", HI, 32'd1);
        issue(4'd1, 32'd5, 32'd6, 1'b1);
        busy_len(n);
        chk("mult_req_busy", 32'(n), 32'd0);
        chk("mult_req_HI", HI, 32'd1);
        chk("mult_req_LO", LO, 32'd3);
        issue(4'd1, 32'd3, 32'd4, 1'b0);
        @(posedge clk); #1; req = 1'b1; MDUOp = 4'd7; A = 32'hDEADBEEF;
        busy_len(n);
        chk("run_req_HI", HI, 32'd0);
        chk("run_req_LO", LO, 32'd12);
        @(posedge clk); #1; req = 1'b0; MDUOp = 4'd0;

        // Signed overflow divide
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        busy_len(n);
        chk("div_ovf_LO", LO, 32'h80000000);
        chk("div_ovf_HI", HI, 32'd0);

        // Divide by zero leaves HI/LO intact
        issue(4'd7, 32'hAA, 32'd0, 1'b0);
        issue(4'd8, 32'hBB, 32'd0, 1'b0);
        issue(4'd3, 32'd123, 32'd0, 1'b0);
        busy_len(n);
`ifdef MDU_DIVZERO_FAST_EN
        chk("divz_busy_cycles", 32'(n), 32'd0);
`else
        chk("divz_busy_cycles", 32'(n), 32'd10);
`endif
        chk("divz_HI", HI, 32'hAA);
        chk("divz_LO", LO, 32'hBB);
        issue(4'd1, 32'd2, 32'd3, 1'b0);
        busy_len(n);
        chk("after_divz_busy", 32'(n), 32'd5);
        chk("after_divz_LO", LO, 32'd6);

        // Asynchronous reset in the middle of a divide
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_HI", HI, 32'd0);
        chk("async_rst_LO", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(4'd1, 32'd7, 32'd6, 1'b0);
        busy_len(n);
        chk("post_rst_busy", 32'(n), 32'd5);
        chk("post_rst_LO", LO, 32'd42);
        chk("post_rst_HI", HI, 32'd0);

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            MDUOp = 4'($urandom_range(0, 10));
            start = (MDUOp >= 4'd1 && MDUOp <= 4'd4) && (m_rem == 0);
            if (m_rem == 0 && $urandom_range(0, 15) == 0) start = 1'b1;
            req = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 7))
                0: A = 32'h80000000;
                1: A = 32'hFFFFFFFF;
                2: A = 32'd0;
                default: A = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: B = 32'hFFFFFFFF;
                1: B = 32'd0;
                2: B = 32'($urandom_range(1, 9));
                default: B = $urandom;
            endcase
        end
        @(posedge clk); #1;
        MDUOp = 4'd0; start = 1'b0; req = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
